// File: rtl/baud_rate_generator.sv
// Oversampled baud tick generator: sample, mid-bit and end-of-bit strobes from a rate table or custom divisor.
// All outputs registered; first strobe div_q enabled edges after a clear/rate change; enable=0 freezes the counters.
module baud_rate_generator #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [2:0]       baud_select,
    input  logic             use_custom,
    input  logic [DIV_W-1:0] custom_div,
    input  logic             sync_clr,
    output logic             sample_enable,
    output logic             mid_enable,
    output logic             bit_enable
);

    localparam int unsigned OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

    // Rounded divisor, saturated to the counter width.
    function automatic logic [DIV_W-1:0] calc_div(input longint baud);
        longint d;
        longint maxv;
        d    = (longint'(CLK_FREQ) + (baud * longint'(OVERSAMPLE)) / 2) / (baud * longint'(OVERSAMPLE));
        maxv = (longint'(1) << DIV_W) - 1;
        if (d > maxv) begin
            d = maxv;
        end
        return d[DIV_W-1:0];
    endfunction

    localparam logic [DIV_W-1:0] DIV0 = calc_div(300);
    localparam logic [DIV_W-1:0] DIV1 = calc_div(1200);
    localparam logic [DIV_W-1:0] DIV2 = calc_div(4800);
    localparam logic [DIV_W-1:0] DIV3 = calc_div(9600);
    localparam logic [DIV_W-1:0] DIV4 = calc_div(19200);
    localparam logic [DIV_W-1:0] DIV5 = calc_div(38400);
    localparam logic [DIV_W-1:0] DIV6 = calc_div(57600);
    localparam logic [DIV_W-1:0] DIV7 = calc_div(115200);

    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
    logic             sample_q, sample_d;
    logic             mid_q, mid_d;
    logic             bit_q, bit_d;
    logic [DIV_W-1:0] tbl_div;
    logic [DIV_W-1:0] div_next;

    always_comb begin
        tbl_div = DIV0;
        case (baud_select)
            3'd0:    tbl_div = DIV0;
            3'd1:    tbl_div = DIV1;
            3'd2:    tbl_div = DIV2;
            3'd3:    tbl_div = DIV3;
            3'd4:    tbl_div = DIV4;
            3'd5:    tbl_div = DIV5;
            3'd6:    tbl_div = DIV6;
            default: tbl_div = DIV7;
        endcase
    end

    assign div_next = use_custom ? custom_div : tbl_div;

    always_comb begin
        div_d    = div_q;
        cnt_d    = cnt_q;
        os_cnt_d = os_cnt_q;
        sample_d = 1'b0;
        mid_d    = 1'b0;
        bit_d    = 1'b0;
        // Realign and rate change share one clear so no partial period escapes.
        if (sync_clr || (div_next != div_q)) begin
            div_d    = div_next;
            cnt_d    = '0;
            os_cnt_d = '0;
        end else if (!enable) begin
            cnt_d    = cnt_q;
        end else if (div_q == '0) begin
            cnt_d    = '0;
        end else if (cnt_q == div_q - DIV_W'(1)) begin
            cnt_d    = '0;
            sample_d = 1'b1;
            mid_d    = (os_cnt_q == OS_MID);
            bit_d    = (os_cnt_q == OS_LAST);
            os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
        end else begin
            cnt_d    = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= DIV0;
            cnt_q    <= '0;
            os_cnt_q <= '0;
            sample_q <= 1'b0;
            mid_q    <= 1'b0;
            bit_q    <= 1'b0;
        end else begin
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            os_cnt_q <= os_cnt_d;
            sample_q <= sample_d;
            mid_q    <= mid_d;
            bit_q    <= bit_d;
        end
    end

    assign sample_enable = sample_q;
    assign mid_enable    = mid_q;
    assign bit_enable    = bit_q;

endmodule

// File: doc/baud_rate_generator.md
Name: baud_rate_generator

Overview:
Parametrised baud tick generator, successor to baud_controller. Derives an oversampled sample strobe from the system clock using a table of eight standard rates or a runtime custom divisor. Also produces bit-rate and mid-bit strobes. A synchronous realign input lets the UART receiver lock tick phase to a detected start-bit edge. Feeds the UART TX and RX datapaths.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
OVERSAMPLE, 16, sample strobes per bit; even, >=2
DIV_W, 16, divisor and counter width in bits

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
enable  input  1  1 = count; 0 = freeze counters
baud_select  input  3  rate table index
use_custom  input  1  1 = use custom_div instead of the table
custom_div  input  DIV_W  clock cycles per sample strobe in custom mode
sync_clr  input  1  synchronous realign of all counters
sample_enable  output  1  one-cycle strobe at baud*OVERSAMPLE
mid_enable  output  1  one-cycle strobe at sample OVERSAMPLE/2 of each bit
bit_enable  output  1  one-cycle strobe at the last sample of each bit

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high. rst assertion clears everything immediately, with no clock edge needed.
- Reset values: cnt=0, os_cnt=0, div_q=table[0], and all three outputs 0. All outputs are registered.
- Rate table: baud_select 000..111 = 300, 1200, 4800, 9600, 19200, 38400, 57600, 115200.
  - Divisor = (CLK_FREQ + baud*OVERSAMPLE/2) / (baud*OVERSAMPLE), rounded, computed at elaboration.
  - Saturates at 2^DIV_W-1.
  - At defaults: 10417, 2604, 651, 326, 163, 81, 54, 27.
- Divisor select: div_next = use_custom ? custom_div : table[baud_select]. It is registered into div_q.
- Rate change: when div_next != div_q on an edge:
  - div_q <= div_next
  - cnt <= 0, os_cnt <= 0
  - all outputs 0 that cycle
  - This happens regardless of enable.
  - The first new strobe arrives on the div-th enabled edge after the change edge. No partial or glitch period occurs.
- Counting (enable=1, no change, no sync_clr):
  - If cnt == div_q-1: cnt <= 0 and sample_enable <= 1.
  - Otherwise: cnt <= cnt+1 and sample_enable <= 0.
  - The strobe period is exactly div_q cycles.
- div_q = 1: sample_enable is held high every cycle.
- div_q = 0: generator halted; cnt stays 0 and all outputs stay 0.
- Oversample counter os_cnt (0..OVERSAMPLE-1), advancing on each sample strobe:
  - mid_enable <= 1 together with the strobe when os_cnt == OVERSAMPLE/2-1.
  - bit_enable <= 1 together with the strobe when os_cnt == OVERSAMPLE-1; os_cnt then wraps to 0.
  - mid_enable and bit_enable are only ever high in cycles where sample_enable is high.
- enable=0: cnt and os_cnt hold and outputs are 0. On re-enable, counting resumes from the held count, so the remaining period completes.
- sync_clr=1: cnt <= 0, os_cnt <= 0, outputs 0 that cycle. The first sample strobe follows div_q enabled edges later.
- Priority, highest first: rst, then sync_clr / rate change (identical clear effect), then enable=0, then normal counting.
- Reset mid-operation: outputs drop asynchronously. After release, the generator restarts as from power-up with div_q taken from the current inputs one edge later. The change rule applies if the inputs differ from table[0].

Test Plan:
- Reset and 115200: rst high 100 ns with baud_select=000, then release and select 111 -> all outputs 0 during reset. After the change, sample_enable every 27 cycles (540 ns), mid_enable every 432 cycles offset 8 strobes, bit_enable every 432 cycles on the 16th strobe.
- Mid-run rate change: switch 111->101 mid-count -> no strobe on the change edge. First strobe 81 cycles after it, then period 81; bit_enable period 1296.
- Custom mode: use_custom=1, custom_div=1 -> sample_enable high every cycle, bit_enable every 16 cycles. custom_div=0 -> all outputs stay 0. custom_div=5 -> period 5.
- Realign: at 9600 (div 326), pulse sync_clr mid-bit -> next sample_enable exactly 326 cycles later. mid_enable on the 8th strobe, bit_enable on the 16th after the clear.
- Freeze: at cnt=10 with div 27, drop enable for 100 cycles -> no strobes. After re-enable, the next strobe comes 17 cycles later.
- Async reset: assert rst between clock edges while sample_enable=1 -> outputs 0 before the next edge, counters cleared. sync_clr with a simultaneous rate change -> single clear, period = new divisor.
